bus_size_sequencer: RTL and testbench
=====================================

# bus_size_sequencer

Initiator-side dynamic bus sizing sequencer for the 68030-style local bus. Accepts one operand transfer request, defined by its starting address low bits, operand size, and direction. Runs as many bus cycles as the responding port's acknowledged width requires. For each cycle it drives the A[1:0]/SIZ[1:0] pair that responder-side byte-lane decoders consume. It reports the operand byte offset so the data path can steer bytes. It sits between the accelerator's memory request logic and the external bus strobe generation.

## Interface
- TIMEOUT, default 255: cycles AS may stay asserted without acknowledge before the cycle is aborted with BERR; valid range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- REQ  in  1  request; sampled only in IDLE.
- REQ_A  in  2  starting address bits [1:0].
- REQ_SIZ  in  2  operand size: 01 byte, 10 word, 11 three-byte, 00 long.
- REQ_RNW  in  1  direction, 1 = read.
- DSACK  in  2  port acknowledge, active-high: 00 none, 01 8-bit port, 10 16-bit port, 11 32-bit port.
- BUSY  out  1  high from accept until DONE/BERR cycle inclusive.
- AS  out  1  bus cycle strobe, active-high.
- A  out  2  address bits [1:0] of current cycle.
- SIZ  out  2  remaining byte count of current cycle, encoded as REQ_SIZ.
- RNW  out  1  latched REQ_RNW.
- OFS  out  2  operand byte offset, meaning bytes already transferred (0..3).
- CARRY  out  1  high once A has wrapped past 3→0 in this operand; upstream adds 4 to the upper address.
- DONE  out  1  one-cycle pulse, operand complete.
- BERR  out  1  one-cycle pulse, timeout abort.

## Operation
- Internal state:
  - remaining count R, 3 bits, 1..4; REQ_SIZ 00 maps to 4.
  - address a, 2 bits.
  - offset OFS.
  - CARRY.
  - timeout counter, 8 bits.
- States: IDLE, CYC, GAP.
- IDLE → CYC when REQ=1.
  - Latch a=REQ_A, R from REQ_SIZ, RNW=REQ_RNW.
  - Clear OFS, CARRY and the timeout counter.
- In CYC:
  - Outputs: AS=1, A=a, SIZ=R mod 4.
  - The timeout counter increments each cycle DSACK=00.
- DSACK≠00 in CYC: port width W = 1, 2 or 4 bytes. Bytes transferred n = min(R, W − (a mod W)).
  - At the edge: a ← (a+n) mod 4. CARRY ← CARRY | (a+n ≥ 4). OFS ← OFS+n. R ← R−n.
  - If R−n = 0: DONE=1 for the next cycle, go to IDLE.
  - Otherwise: go to GAP.
- GAP: AS=0 for exactly one cycle, then CYC with the updated a/R.
- Timeout: counter reaches TIMEOUT in CYC with DSACK=00 → BERR=1 for the next cycle and go to IDLE. A partial transfer is not resumed.
- Ignored inputs:
  - REQ outside IDLE.
  - DSACK outside CYC.
  - DSACK changes after the acknowledging edge.
- A, SIZ, OFS and CARRY hold their last values in IDLE. They are only meaningful while AS=1.

## Timing
- Reset values: state IDLE, AS=0, BUSY=0, DONE=0, BERR=0, A=00, SIZ=00, RNW=0, OFS=00, CARRY=0.
- RST mid-operation: AS falls on the first edge with RST=1. No DONE or BERR is issued.
- REQ high at edge t → AS=1 and BUSY=1 from t+1.
- Ack at edge t → AS=0 at t+1. If more bytes remain, AS=1 again at t+2.
- Minimum bus cycle is 1 AS-high cycle plus 1 gap cycle.
- Best case: a long to a 32-bit port at a=0 gives DONE two cycles after REQ is sampled.
- DONE/BERR cycle: AS=0, BUSY=1. BUSY drops the following cycle.
- A new REQ is accepted on the edge after DONE/BERR. Back-to-back requests therefore have one idle cycle.
- Timeout: AS is high for exactly TIMEOUT cycles before BERR.
- Wrap: A is 2-bit modulo. CARRY sets on the acknowledge edge that produces the wrap and is visible with the next AS.

## Test plan
- Long, a=0, DSACK=01 every cycle:
  - (A,SIZ,OFS) sequence is (0,00,0) (1,11,1) (2,10,2) (3,01,3).
  - DONE after the 4th ack; CARRY=0 throughout.
- Long, a=1, DSACK=11:
  - Cycle 1 is (1,00,0) and transfers 3 bytes.
  - Cycle 2 is (0,01,3) with CARRY=1, then DONE.
- Word, a=3, DSACK=10:
  - Cycle 1 is (3,10,0) and transfers 1 byte.
  - Cycle 2 is (0,01,1) with CARRY=1, then DONE.
- Three-byte, a=0:
  - Cycle 1 is acked 10, giving (0,11,0) and n=2.
  - Cycle 2 is acked 01, giving (2,01,2).
  - DONE follows.
- Timeout, TIMEOUT=4, DSACK held 00:
  - AS high exactly 4 cycles, then BERR pulse and BUSY low next cycle.
  - A new REQ is accepted afterwards.
- Reset and stray inputs:
  - RST asserted while AS=1 → all outputs at reset values next cycle, no DONE.
  - REQ pulsed while BUSY is ignored.
  - DSACK=11 during GAP is ignored.

Source files
------------

// File: rtl/bus_size_sequencer.sv
// Initiator-side dynamic bus sizing sequencer: splits one operand transfer into
// bus cycles sized by the responder's DSACK port width, driving A[1:0]/SIZ[1:0].
module bus_size_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [1:0] REQ_A,
  input  logic [1:0] REQ_SIZ,
  input  logic       REQ_RNW,
  input  logic [1:0] DSACK,
  output logic       BUSY,
  output logic       AS,
  output logic [1:0] A,
  output logic [1:0] SIZ,
  output logic       RNW,
  output logic [1:0] OFS,
  output logic       CARRY,
  output logic       DONE,
  output logic       BERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CYC  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [2:0] rem;
  logic [1:0] addr;
  logic [7:0] tcnt;

  logic [2:0] width;
  logic [2:0] amod;
  logic [2:0] avail;
  logic [2:0] nbytes;
  logic [2:0] sum;
  logic [2:0] rem_next;

  // Bytes moved this cycle: limited by remaining count and by the distance from
  // the current address to the end of the acknowledging port's width.
  always_comb begin
    width = 3'd0;
    amod  = 3'd0;
    case (DSACK)
      2'b01: begin width = 3'd1; amod = 3'd0;                end
      2'b10: begin width = 3'd2; amod = {2'b00, addr[0]};    end
      2'b11: begin width = 3'd4; amod = {1'b0, addr};        end
      default: begin width = 3'd0; amod = 3'd0;              end
    endcase
    avail    = width - amod;
    nbytes   = (rem < avail) ? rem : avail;
    sum      = {1'b0, addr} + nbytes;
    rem_next = rem - nbytes;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      rem   <= '0;
      addr  <= '0;
      tcnt  <= '0;
      RNW   <= 1'b0;
      OFS   <= '0;
      CARRY <= 1'b0;
      DONE  <= 1'b0;
      BERR  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      BERR <= 1'b0;
      case (state)
        S_IDLE: begin
          // The DONE/BERR cycle still counts as busy, so REQ is not taken there.
          if (REQ && !DONE && !BERR) begin
            state <= S_CYC;
            addr  <= REQ_A;
            rem   <= (REQ_SIZ == 2'b00) ? 3'd4 : {1'b0, REQ_SIZ};
            RNW   <= REQ_RNW;
            OFS   <= '0;
            CARRY <= 1'b0;
            tcnt  <= '0;
          end
        end
        S_CYC: begin
          if (DSACK != 2'b00) begin
            addr  <= sum[1:0];
            CARRY <= CARRY | sum[2];
            OFS   <= OFS + nbytes[1:0];
            rem   <= rem_next;
            // Each bus cycle gets the full timeout window.
            tcnt  <= '0;
            if (rem_next == 3'd0) begin
              DONE  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end else if (tcnt == TMO_LAST) begin
            BERR  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_GAP: begin
          state <= S_CYC;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign AS   = (state == S_CYC);
  assign BUSY = (state != S_IDLE) || DONE || BERR;
  assign A    = addr;
  assign SIZ  = rem[1:0];

endmodule

// File: tb/tb_bus_size_sequencer.sv
// Scoreboard bench for bus_size_sequencer: directed transfers push expected bus
// cycles/events; a negedge monitor pops and compares whenever AS/DONE/BERR show.
module tb_bus_size_sequencer;

  localparam int unsigned TMO = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ;
  logic [1:0] REQ_A;
  logic [1:0] REQ_SIZ;
  logic       REQ_RNW;
  logic [1:0] DSACK;
  logic       BUSY;
  logic       AS;
  logic [1:0] A;
  logic [1:0] SIZ;
  logic       RNW;
  logic [1:0] OFS;
  logic       CARRY;
  logic       DONE;
  logic       BERR;

  bus_size_sequencer #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_A(REQ_A), .REQ_SIZ(REQ_SIZ),
    .REQ_RNW(REQ_RNW), .DSACK(DSACK), .BUSY(BUSY), .AS(AS), .A(A), .SIZ(SIZ),
    .RNW(RNW), .OFS(OFS), .CARRY(CARRY), .DONE(DONE), .BERR(BERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] siz;
    logic [1:0] ofs;
    logic       carry;
    logic       rnw;
  } cyc_t;

  cyc_t        exp_cyc[$];
  int          exp_evt[$];   // 1 = DONE, 2 = BERR
  cyc_t        mon_c;
  int          mon_e;
  bit          mon_en = 1'b0;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cyc(input logic [1:0] a, input logic [1:0] siz, input logic [1:0] ofs,
                          input logic carry, input logic rnw);
    cyc_t c;
    c = '{a: a, siz: siz, ofs: ofs, carry: carry, rnw: rnw};
    exp_cyc.push_back(c);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (AS) begin
        check("as_expected", 32'(exp_cyc.size() > 0), 1);
        if (exp_cyc.size() > 0) begin
          mon_c = exp_cyc.pop_front();
          check("cycle_a_siz_ofs_carry_rnw", {24'd0, A, SIZ, OFS, CARRY, RNW}, {24'd0, mon_c});
        end
      end
      if (DONE || BERR) begin
        check("event_expected", 32'(exp_evt.size() > 0), 1);
        if (exp_evt.size() > 0) begin
          mon_e = exp_evt.pop_front();
          check("event_kind", {DONE, BERR}, (mon_e == 1) ? 2'b10 : 2'b01);
          check("event_busy", BUSY, 1);
          check("event_as", AS, 0);
        end
      end
    end
  end

  // acks holds up to four DSACK codes, first in bits [1:0].
  task automatic xfer(input logic [1:0] a, input logic [1:0] siz, input logic rnw,
                      input int nack, input logic [7:0] acks, input bit stray);
    int k;
    @(negedge CLK);
    REQ = 1'b1; REQ_A = a; REQ_SIZ = siz; REQ_RNW = rnw;
    @(negedge CLK);
    REQ = 1'b0; REQ_A = 2'b00; REQ_SIZ = 2'b00; REQ_RNW = 1'b0;
    check("as_after_req", AS, 1);
    check("busy_after_req", BUSY, 1);
    for (int i = 0; i < nack; i++) begin
      k = 0;
      while (!AS && k < 50) begin
        @(negedge CLK);
        k++;
      end
      check("as_wait", AS, 1);
      DSACK = acks[2*i +: 2];
      @(negedge CLK);
      DSACK = 2'b00;
      check("as_low_after_ack", AS, 0);
      if (stray && i == 0) begin
        DSACK = 2'b11; REQ = 1'b1; REQ_A = 2'b11; REQ_SIZ = 2'b01;
        @(negedge CLK);
        DSACK = 2'b00; REQ = 1'b0; REQ_A = 2'b00; REQ_SIZ = 2'b00;
      end
    end
    if (nack == 0) begin
      k = 0;
      while (AS && k < 300) begin
        @(negedge CLK);
        k++;
      end
      check("as_high_cycles", k, TMO);
      check("berr_pulse", BERR, 1);
    end else begin
      check("done_pulse", DONE, 1);
    end
    @(negedge CLK);
    check("busy_low", BUSY, 0);
    check("done_berr_cleared", {DONE, BERR}, 0);
    check("idle_as", AS, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; REQ_A = 2'b00; REQ_SIZ = 2'b00; REQ_RNW = 1'b0; DSACK = 2'b00;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {AS, BUSY, DONE, BERR, A, SIZ, RNW, OFS, CARRY}, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    // long, a=0, 8-bit port every cycle
    push_cyc(2'd0, 2'b00, 2'd0, 1'b0, 1'b1);
    push_cyc(2'd1, 2'b11, 2'd1, 1'b0, 1'b1);
    push_cyc(2'd2, 2'b10, 2'd2, 1'b0, 1'b1);
    push_cyc(2'd3, 2'b01, 2'd3, 1'b0, 1'b1);
    exp_evt.push_back(1);
    xfer(2'd0, 2'b00, 1'b1, 4, 8'b01_01_01_01, 1'b0);

    // long, a=1, 32-bit port: 3 bytes then wrapped 1 byte
    push_cyc(2'd1, 2'b00, 2'd0, 1'b0, 1'b0);
    push_cyc(2'd0, 2'b01, 2'd3, 1'b1, 1'b0);
    exp_evt.push_back(1);
    xfer(2'd1, 2'b00, 1'b0, 2, 8'b00_00_11_11, 1'b0);

    // word, a=3, 16-bit port
    push_cyc(2'd3, 2'b10, 2'd0, 1'b0, 1'b1);
    push_cyc(2'd0, 2'b01, 2'd1, 1'b1, 1'b1);
    exp_evt.push_back(1);
    xfer(2'd3, 2'b10, 1'b1, 2, 8'b00_00_10_10, 1'b0);

    // three-byte, a=0, acked 16 then 8; stray REQ and DSACK during the gap
    push_cyc(2'd0, 2'b11, 2'd0, 1'b0, 1'b0);
    push_cyc(2'd2, 2'b01, 2'd2, 1'b0, 1'b0);
    exp_evt.push_back(1);
    xfer(2'd0, 2'b11, 1'b0, 2, 8'b00_00_01_10, 1'b1);

    // best case: long, a=0, 32-bit port in one cycle
    push_cyc(2'd0, 2'b00, 2'd0, 1'b0, 1'b1);
    exp_evt.push_back(1);
    xfer(2'd0, 2'b00, 1'b1, 1, 8'b00_00_00_11, 1'b0);

    // long, a=2, 16-bit port: wraps after first word
    push_cyc(2'd2, 2'b00, 2'd0, 1'b0, 1'b0);
    push_cyc(2'd0, 2'b10, 2'd2, 1'b1, 1'b0);
    exp_evt.push_back(1);
    xfer(2'd2, 2'b00, 1'b0, 2, 8'b00_00_10_10, 1'b0);

    // timeout with no acknowledge
    for (int i = 0; i < int'(TMO); i++) push_cyc(2'd2, 2'b10, 2'd0, 1'b0, 1'b1);
    exp_evt.push_back(2);
    xfer(2'd2, 2'b10, 1'b1, 0, 8'h00, 1'b0);

    // new request after BERR
    push_cyc(2'd2, 2'b01, 2'd0, 1'b0, 1'b0);
    exp_evt.push_back(1);
    xfer(2'd2, 2'b01, 1'b0, 1, 8'b00_00_00_01, 1'b0);

    // reset while AS is high: no DONE, all outputs back to reset values
    push_cyc(2'd1, 2'b00, 2'd0, 1'b0, 1'b1);
    @(negedge CLK);
    REQ = 1'b1; REQ_A = 2'd1; REQ_SIZ = 2'b00; REQ_RNW = 1'b1;
    @(negedge CLK);
    REQ = 1'b0; REQ_A = 2'b00; REQ_SIZ = 2'b00; REQ_RNW = 1'b0;
    check("rst_test_as", AS, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midop_reset_outputs", {AS, BUSY, DONE, BERR, A, SIZ, RNW, OFS, CARRY}, 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("post_reset_idle", {AS, BUSY}, 0);

    check("cycles_left", exp_cyc.size(), 0);
    check("events_left", exp_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
